// File: rtl/ts_rcv.sv
// Training-set receiver: validates incoming TS1/TS2 ordered sets and counts consecutive identical ones.
// Optional malformed-beat counter is enabled by defining TS_RCV_ERR_CNT_EN.
module ts_rcv #(
    parameter int RCV_TARGET = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     ts_in,
    input  logic             ts_in_valid,
    output logic             ts_in_ready,
    input  logic             ts_clear,
    output logic             ts_clear_ack,
    output logic [1:0]       rx_ts_type,
    output logic [CNT_W-1:0] rx_ts_cnt,
    output logic             rx_ts_rcvd_enough,
    output logic [7:0]       rx_link_num,
    output logic [7:0]       rx_lane_num,
    output logic [5:0]       rx_rate,
    output logic             rx_err,
    output logic [15:0]      rx_err_cnt
);
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    localparam logic [CNT_W-1:0] TARGET  = CNT_W'(RCV_TARGET);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [119:0]     ref_q, ref_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       type_q, type_d;
    logic             enough_q, enough_d;
    logic [7:0]       link_q, link_d, lane_q, lane_d;
    logic [5:0]       rate_q, rate_d;
    logic             err_q, err_d, ack_q, ack_d;
    logic             accept, tail_same, good;

    assign ts_in_ready = rst_n & ~ts_clear;
    assign accept      = ts_in_valid & ts_in_ready;

    // Symbols 6..15 occupy ts_in[79:0]; all must match symbol15.
    always_comb begin
        tail_same = 1'b1;
        for (int i = 1; i < 10; i++) begin
            if (ts_in[8*i +: 8] != ts_in[7:0]) tail_same = 1'b0;
        end
    end

    assign good = (ts_in[127:120] == 8'hBC) && tail_same &&
                  ((ts_in[7:0] == 8'h4A) || (ts_in[7:0] == 8'h45));

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        type_d   = type_q;
        enough_d = enough_q;
        link_d   = link_q;
        lane_d   = lane_q;
        rate_d   = rate_q;
        err_d    = 1'b0;
        ack_d    = 1'b0;
        if (ts_clear) begin
            state_d  = IDLE;
            ref_d    = '0;
            cnt_d    = '0;
            type_d   = 2'b00;
            enough_d = 1'b0;
            ack_d    = 1'b1;
        end else if (accept) begin
            if (!good) begin
                err_d   = 1'b1;
                cnt_d   = '0;
                type_d  = 2'b00;
                state_d = IDLE;
            end else if (state_q == IDLE || ts_in[119:0] != ref_q) begin
                ref_d   = ts_in[119:0];
                cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                type_d  = (ts_in[7:0] == 8'h4A) ? 2'b01 : 2'b10;
                link_d  = ts_in[119:112];
                lane_d  = ts_in[111:104];
                rate_d  = ts_in[93:88];
                state_d = TRACK;
            end else begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
            // Lock as soon as the count reaches the target while tracking.
            if (good && state_d == TRACK && cnt_d >= TARGET) begin
                enough_d = 1'b1;
                state_d  = LOCKED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ref_q    <= '0;
            cnt_q    <= '0;
            type_q   <= 2'b00;
            enough_q <= 1'b0;
            link_q   <= 8'h00;
            lane_q   <= 8'h00;
            rate_q   <= 6'h00;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            enough_q <= enough_d;
            link_q   <= link_d;
            lane_q   <= lane_d;
            rate_q   <= rate_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
        end
    end

`ifdef TS_RCV_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    // Survives ts_clear; only reset zeroes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 16'h0000;
        end else if (err_d && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end
    end
    assign rx_err_cnt = err_cnt_q;
`else
    assign rx_err_cnt = 16'h0000;
`endif

    assign ts_clear_ack      = ack_q;
    assign rx_ts_type        = type_q;
    assign rx_ts_cnt         = cnt_q;
    assign rx_ts_rcvd_enough = enough_q;
    assign rx_link_num       = link_q;
    assign rx_lane_num       = lane_q;
    assign rx_rate           = rate_q;
    assign rx_err            = err_q;
endmodule

// File: tb/tb_ts_rcv.sv
// Directed self-checking bench for ts_rcv with immediate assertions at each check point.
module tb_ts_rcv;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] ts_in = '0;
    logic         ts_in_valid = 1'b0;
    logic         ts_in_ready;
    logic         ts_clear = 1'b0;
    logic         ts_clear_ack;
    logic [1:0]   rx_ts_type;
    logic [7:0]   rx_ts_cnt;
    logic         rx_ts_rcvd_enough;
    logic [7:0]   rx_link_num, rx_lane_num;
    logic [5:0]   rx_rate;
    logic         rx_err;
    logic [15:0]  rx_err_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [127:0] TS1 = {8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00, {10{8'h4A}}};
    localparam logic [127:0] TS2 = {8'hBC, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00, {10{8'h45}}};
    localparam logic [127:0] BAD = {8'h1C, 8'hF7, 8'hF7, 8'hFF, 8'h02, 8'h00, {10{8'h4A}}};
`ifdef TS_RCV_ERR_CNT_EN
    localparam logic [15:0] ERR1 = 16'h0001;
`else
    localparam logic [15:0] ERR1 = 16'h0000;
`endif

    ts_rcv #(.RCV_TARGET(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ts_in(ts_in), .ts_in_valid(ts_in_valid),
        .ts_in_ready(ts_in_ready), .ts_clear(ts_clear), .ts_clear_ack(ts_clear_ack),
        .rx_ts_type(rx_ts_type), .rx_ts_cnt(rx_ts_cnt), .rx_ts_rcvd_enough(rx_ts_rcvd_enough),
        .rx_link_num(rx_link_num), .rx_lane_num(rx_lane_num), .rx_rate(rx_rate),
        .rx_err(rx_err), .rx_err_cnt(rx_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [127:0] d, input logic c);
        @(negedge clk);
        ts_in_valid = v;
        ts_in       = d;
        ts_clear    = c;
        @(posedge clk);
        #1;
        $display("step v=%0d clr=%0d sym0=%02h -> type=%0d cnt=%0d enough=%0d err=%0d ack=%0d",
                 v, c, d[127:120], rx_ts_type, rx_ts_cnt, rx_ts_rcvd_enough, rx_err, ts_clear_ack);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_type"},   32'(rx_ts_type), 32'h0);
        chk({tag, "_cnt"},    32'(rx_ts_cnt), 32'h0);
        chk({tag, "_enough"}, 32'(rx_ts_rcvd_enough), 32'h0);
        chk({tag, "_link"},   32'(rx_link_num), 32'h0);
        chk({tag, "_lane"},   32'(rx_lane_num), 32'h0);
        chk({tag, "_rate"},   32'(rx_rate), 32'h0);
        chk({tag, "_errcnt"}, 32'(rx_err_cnt), 32'h0);
        chk({tag, "_ready"},  32'(ts_in_ready), 32'h0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(ts_in_ready), 32'h1);

        // 8 back-to-back TS1 beats, lock on the 8th
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, TS1, 1'b0);
            chk($sformatf("ts1_cnt_%0d", k), 32'(rx_ts_cnt), 32'(k));
            chk($sformatf("ts1_enough_%0d", k), 32'(rx_ts_rcvd_enough), (k == 8) ? 32'h1 : 32'h0);
        end
        chk("ts1_type", 32'(rx_ts_type), 32'h1);
        chk("ts1_link", 32'(rx_link_num), 32'hF7);
        chk("ts1_lane", 32'(rx_lane_num), 32'hF7);
        chk("ts1_rate", 32'(rx_rate), 32'h02);

        // Idle cycle with garbage on the bus: outputs hold
        step(1'b0, BAD, 1'b0);
        chk("idle_cnt", 32'(rx_ts_cnt), 32'h8);
        chk("idle_err", 32'(rx_err), 32'h0);

        // Malformed beat while locked
        step(1'b1, BAD, 1'b0);
        chk("bad_err", 32'(rx_err), 32'h1);
        chk("bad_cnt", 32'(rx_ts_cnt), 32'h0);
        chk("bad_type", 32'(rx_ts_type), 32'h0);
        chk("bad_enough", 32'(rx_ts_rcvd_enough), 32'h1);
        chk("bad_errcnt", 32'(rx_err_cnt), 32'(ERR1));
        chk("bad_link", 32'(rx_link_num), 32'hF7);
        step(1'b0, TS1, 1'b0);
        chk("bad_err_pulse", 32'(rx_err), 32'h0);

        // Clear concurrent with a valid beat
        @(negedge clk);
        ts_clear = 1'b1;
        ts_in_valid = 1'b1;
        #1;
        chk("clr_ready", 32'(ts_in_ready), 32'h0);
        step(1'b1, TS1, 1'b1);
        chk("clr_ack", 32'(ts_clear_ack), 32'h1);
        chk("clr_cnt", 32'(rx_ts_cnt), 32'h0);
        chk("clr_type", 32'(rx_ts_type), 32'h0);
        chk("clr_enough", 32'(rx_ts_rcvd_enough), 32'h0);
        step(1'b0, TS1, 1'b0);
        chk("clr_ack_pulse", 32'(ts_clear_ack), 32'h0);
        chk("clr_beat_dropped", 32'(rx_ts_cnt), 32'h0);
        chk("clr_errcnt_kept", 32'(rx_err_cnt), 32'(ERR1));

        // Clear held 3 cycles -> 3 acks
        for (int k = 0; k < 3; k++) begin
            step(1'b0, TS1, 1'b1);
            chk($sformatf("clr_hold_ack_%0d", k), 32'(ts_clear_ack), 32'h1);
        end
        step(1'b0, TS1, 1'b0);
        chk("clr_hold_end", 32'(ts_clear_ack), 32'h0);

        // 5 TS1 then 3 TS2
        for (int k = 1; k <= 5; k++) step(1'b1, TS1, 1'b0);
        chk("mix_ts1_cnt", 32'(rx_ts_cnt), 32'h5);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, TS2, 1'b0);
            chk($sformatf("mix_ts2_cnt_%0d", k), 32'(rx_ts_cnt), 32'(k));
        end
        chk("mix_type", 32'(rx_ts_type), 32'h2);
        chk("mix_enough", 32'(rx_ts_rcvd_enough), 32'h0);

        // 300 identical TS1: saturation at 255
        step(1'b0, TS1, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            step(1'b1, TS1, 1'b0);
            chk($sformatf("sat_cnt_%0d", k), 32'(rx_ts_cnt), (k > 255) ? 32'd255 : 32'(k));
        end
        chk("sat_enough", 32'(rx_ts_rcvd_enough), 32'h1);

        // Mismatch while locked: retrack, flag stays set
        step(1'b1, TS2, 1'b0);
        chk("lock_mm_cnt", 32'(rx_ts_cnt), 32'h1);
        chk("lock_mm_type", 32'(rx_ts_type), 32'h2);
        chk("lock_mm_enough", 32'(rx_ts_rcvd_enough), 32'h1);

        // Asynchronous reset between edges, with a beat in flight
        @(negedge clk);
        ts_in_valid = 1'b1;
        ts_in = TS2;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        chk("arst_err", 32'(rx_err), 32'h0);
        @(posedge clk);
        #1;
        chk("arst_beat_dropped", 32'(rx_ts_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, TS1, 1'b0);
        chk("post_rst_cnt", 32'(rx_ts_cnt), 32'h1);
        chk("post_rst_type", 32'(rx_ts_type), 32'h1);
        step(1'b0, TS1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
